// File: rtl/ddfs_pkg.sv
// Shared DDFS constants: default widths, frequency-control codes and the
// code-to-(divider-1) table used by the prescaler and the frequency converter.
package ddfs_pkg;

  localparam int unsigned PHASE_W_DEF = 10;
  localparam int unsigned PRESC_W_DEF = 20;
  localparam int unsigned FW_W        = 7;
  localparam int unsigned CODE_W      = 3;

  typedef enum logic [CODE_W-1:0] {
    FC_DIV2   = 3'd0,
    FC_DIV10  = 3'd1,
    FC_DIV100 = 3'd2,
    FC_DIV1K  = 3'd3,
    FC_DIV10K = 3'd4,
    FC_DIV100K = 3'd5,
    FC_DIV1M  = 3'd6,
    FC_ALIAS2 = 3'd7
  } freq_code_e;

  typedef logic [PRESC_W_DEF-1:0] presc_t;

  // Code 7 is unassigned and aliases code 0.
  function automatic presc_t div_m1(input logic [CODE_W-1:0] code);
    presc_t d;
    case (code)
      FC_DIV10:   d = 20'd9;
      FC_DIV100:  d = 20'd99;
      FC_DIV1K:   d = 20'd999;
      FC_DIV10K:  d = 20'd9999;
      FC_DIV100K: d = 20'd99999;
      FC_DIV1M:   d = 20'd999999;
      default:    d = 20'd1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/ddfs_prescaler.sv
// Prescaler: counts 0..div-1 while enabled and flags the last count with a
// one-cycle tick; held at 0 while disabled.
module ddfs_prescaler
  import ddfs_pkg::*;
#(
  parameter int unsigned PRESC_W = PRESC_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [CODE_W-1:0] code,
  output logic              tick
);

  logic [PRESC_W-1:0] r_cnt;
  logic [PRESC_W-1:0] w_last;

  assign w_last = PRESC_W'(div_m1(code));
  assign tick   = en && (r_cnt == w_last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (!en || tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + PRESC_W'(1);
    end
  end

endmodule

// File: rtl/ddfs_phase_generator.sv
// DDFS phase accumulator with shadowed frequency settings applied only at a
// phase wrap (or immediately while idle). Optional DDFS_WRAP_PULSE_EN adds wrap_pulse.
module ddfs_phase_generator
  import ddfs_pkg::*;
#(
  parameter int unsigned PHASE_W = PHASE_W_DEF,
  parameter int unsigned PRESC_W = PRESC_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [FW_W-1:0]    fw,
  input  logic [CODE_W-1:0]  freq_control,
  input  logic               update,
  output logic [PHASE_W-1:0] phase,
  output logic               pending
`ifdef DDFS_WRAP_PULSE_EN
  ,
  output logic               wrap_pulse
`endif
);

  logic [FW_W-1:0]    r_fw_sh;
  logic [FW_W-1:0]    r_fw_act;
  logic [CODE_W-1:0]  r_code_sh;
  logic [CODE_W-1:0]  r_code_act;
  logic               r_pending;
  logic [PHASE_W-1:0] r_phase;

  logic               w_tick;
  logic [PHASE_W:0]   w_sum;
  logic               w_wrap;
  logic               w_apply;

  ddfs_prescaler #(
    .PRESC_W (PRESC_W)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .code (r_code_act),
    .tick (w_tick)
  );

  assign w_sum   = {1'b0, r_phase} + (PHASE_W+1)'(r_fw_act) + (PHASE_W+1)'(1);
  assign w_wrap  = w_tick && w_sum[PHASE_W];
  // Running: swap settings only on the wrap edge so a period is never split.
  assign w_apply = r_pending && (en ? w_wrap : 1'b1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fw_sh    <= '0;
      r_fw_act   <= '0;
      r_code_sh  <= '0;
      r_code_act <= '0;
      r_pending  <= 1'b0;
      r_phase    <= '0;
    end else begin
      if (update) begin
        r_fw_sh   <= fw;
        r_code_sh <= freq_control;
      end
      if (w_apply) begin
        r_fw_act   <= r_fw_sh;
        r_code_act <= r_code_sh;
      end
      // A capture coinciding with an apply stays pending for the next one.
      if (update) begin
        r_pending <= 1'b1;
      end else if (w_apply) begin
        r_pending <= 1'b0;
      end
      if (w_tick) begin
        r_phase <= w_sum[PHASE_W-1:0];
      end
    end
  end

  assign phase   = r_phase;
  assign pending = r_pending;

`ifdef DDFS_WRAP_PULSE_EN
  logic r_wrap_pulse;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wrap_pulse <= 1'b0;
    end else begin
      r_wrap_pulse <= w_wrap;
    end
  end

  assign wrap_pulse = r_wrap_pulse;
`endif

endmodule

// File: tb/tb_ddfs_phase_generator.sv
// Directed self-checking bench for ddfs_phase_generator (default widths).
module tb_ddfs_phase_generator;

  logic       clk;
  logic       rst;
  logic       en;
  logic [6:0] fw;
  logic [2:0] freq_control;
  logic       update;
  logic [9:0] phase;
  logic       pending;
`ifdef DDFS_WRAP_PULSE_EN
  logic       wrap_pulse;
`endif

  int unsigned n_checks;
  int unsigned n_fail;

  ddfs_phase_generator #(
    .PHASE_W (10),
    .PRESC_W (20)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .fw           (fw),
    .freq_control (freq_control),
    .update       (update),
    .phase        (phase),
    .pending      (pending)
`ifdef DDFS_WRAP_PULSE_EN
    ,
    .wrap_pulse   (wrap_pulse)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    rst          = 1'b1;
    en           = 1'b0;
    fw           = '0;
    freq_control = '0;
    update       = 1'b0;

    // Reset state
    step(2);
    check_eq("rst_phase", 32'(phase), 0);
    check_eq("rst_pending", 32'(pending), 0);
`ifdef DDFS_WRAP_PULSE_EN
    check_eq("rst_wrap_pulse", 32'(wrap_pulse), 0);
`endif
    rst = 1'b0;

    // Code 0, fw 0: +1 every 2 cycles, wrap at cycle 2048
    en = 1'b1;
    step(1);
    check_eq("c0_cyc1", 32'(phase), 0);
    step(1);
    check_eq("c0_cyc2", 32'(phase), 1);
    step(2044);
    check_eq("c0_cyc2046", 32'(phase), 1023);
    step(1);
    check_eq("c0_cyc2047", 32'(phase), 1023);
    step(1);
    check_eq("c0_cyc2048_wrap", 32'(phase), 0);
`ifdef DDFS_WRAP_PULSE_EN
    check_eq("c0_wrap_pulse", 32'(wrap_pulse), 1);
    step(1);
    check_eq("c0_wrap_pulse_off", 32'(wrap_pulse), 0);
`endif

    // Idle update to code 1, fw 127
    en           = 1'b0;
    fw           = 7'd127;
    freq_control = 3'd1;
    update       = 1'b1;
    step(1);
    update = 1'b0;
    check_eq("c1_pending_set", 32'(pending), 1);
    step(1);
    check_eq("c1_pending_clr", 32'(pending), 0);
    check_eq("c1_phase_held", 32'(phase), 0);
    en = 1'b1;
    step(9);
    check_eq("c1_cyc9", 32'(phase), 0);
    step(1);
    check_eq("c1_cyc10", 32'(phase), 128);
    step(60);
    check_eq("c1_cyc70", 32'(phase), 896);
    step(10);
    check_eq("c1_cyc80_wrap", 32'(phase), 0);
`ifdef DDFS_WRAP_PULSE_EN
    check_eq("c1_wrap_pulse", 32'(wrap_pulse), 1);
`endif

    // Mid-run update deferred to the wrap
    rst = 1'b1;
    en  = 1'b0;
    #2;
    check_eq("rst2_phase", 32'(phase), 0);
    step(1);
    rst = 1'b0;
    en  = 1'b1;
    step(1000);
    check_eq("upd_phase500", 32'(phase), 500);
    fw           = 7'd3;
    freq_control = 3'd2;
    update       = 1'b1;
    step(1);
    update = 1'b0;
    check_eq("upd_pending", 32'(pending), 1);
    check_eq("upd_no_step", 32'(phase), 500);
    step(1);
    check_eq("upd_old_step", 32'(phase), 501);
    step(1046);
    check_eq("upd_wrap", 32'(phase), 0);
    check_eq("upd_applied", 32'(pending), 0);
    step(99);
    check_eq("c2_cyc99", 32'(phase), 0);
    step(1);
    check_eq("c2_cyc100", 32'(phase), 4);
    step(100);
    check_eq("c2_cyc200", 32'(phase), 8);

    // Code 7 behaves as code 0
    en           = 1'b0;
    fw           = 7'd1;
    freq_control = 3'd7;
    update       = 1'b1;
    step(1);
    update = 1'b0;
    step(1);
    check_eq("c7_applied", 32'(pending), 0);
    check_eq("c7_held", 32'(phase), 8);
    en = 1'b1;
    step(1);
    check_eq("c7_cyc1", 32'(phase), 8);
    step(1);
    check_eq("c7_cyc2", 32'(phase), 10);
    step(2);
    check_eq("c7_cyc4", 32'(phase), 12);

    // Async reset mid-period with settings pending
    fw           = 7'd5;
    freq_control = 3'd1;
    update       = 1'b1;
    step(1);
    update = 1'b0;
    check_eq("rst3_pre_pending", 32'(pending), 1);
    rst = 1'b1;
    en  = 1'b0;
    #2;
    check_eq("rst3_async_phase", 32'(phase), 0);
    check_eq("rst3_async_pending", 32'(pending), 0);
    step(1);
    rst = 1'b0;
    en  = 1'b1;
    step(1);
    check_eq("rst3_cyc1", 32'(phase), 0);
    step(1);
    check_eq("rst3_cyc2", 32'(phase), 1);
    check_eq("rst3_discarded", 32'(pending), 0);

    // Idle update fw 10 applies next edge, phase held
    en           = 1'b0;
    fw           = 7'd10;
    freq_control = 3'd0;
    update       = 1'b1;
    step(1);
    update = 1'b0;
    check_eq("idle_pending", 32'(pending), 1);
    step(1);
    check_eq("idle_applied", 32'(pending), 0);
    step(3);
    check_eq("idle_held", 32'(phase), 1);
    en = 1'b1;
    step(1);
    check_eq("idle_cyc1", 32'(phase), 1);
    step(1);
    check_eq("idle_cyc2", 32'(phase), 12);

    // Update coinciding with the wrap: older shadow wins, new one stays pending
    fw     = 7'd0;
    update = 1'b1;
    step(1);
    update = 1'b0;
    check_eq("coin_pending_a", 32'(pending), 1);
    step(182);
    check_eq("coin_pre_wrap", 32'(phase), 1013);
    fw     = 7'd1;
    update = 1'b1;
    step(1);
    update = 1'b0;
    check_eq("coin_wrap", 32'(phase), 0);
    check_eq("coin_pending_b", 32'(pending), 1);
`ifdef DDFS_WRAP_PULSE_EN
    check_eq("coin_wrap_pulse", 32'(wrap_pulse), 1);
`endif
    step(2);
    check_eq("coin_old_step", 32'(phase), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
